// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ==================================================================
// Module   : if_fetch_unit_pkg
// Purpose  : Shared widths, defaults, FSM encoding and helpers for
//            the instruction-fetch stage.
// Revision : 1.0 - initial release
// ==================================================================
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [31:0]        DEF_RESET_PC  = 32'h0040_0000;
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = {INSTR_W{1'b0}};

  // Fetch FSM: REQ issues a request, WAIT has one outstanding fetch,
  // HOLD parks a response while ID is stalled.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_skid_buffer.sv
`default_nettype none
// ==================================================================
// Module   : if_skid_buffer
// Purpose  : One-entry instruction/PC holding register used to park
//            a memory response that arrives while ID is stalled.
// Revision : 1.0 - initial release
// ==================================================================
module if_skid_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc,
  input  logic               pop,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc
);

  // Capture on load, release on pop; a load takes priority over a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= {INSTR_W{1'b0}};
      pc    <= 32'h0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ==================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, issues requests to
//            a variable-latency instruction memory, holds the IF/ID
//            register and applies single-delay-slot redirects from ID.
// Options  : IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
// Revision : 1.0 - initial release
// ==================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = DEF_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               is_branch,
  input  logic [31:0]        branch_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic               id_valid,
  output logic [31:0]        delay_slot_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic               r_run;          // low for the first cycle after reset
  logic [31:0]        r_pc;
  logic               r_pending;
  logic [31:0]        r_pending_pc;

  logic               w_skid_load;
  logic               w_skid_pop;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [31:0]        w_skid_pc;

  logic               w_fetch_done;   // a fetched word enters IF/ID this cycle
  logic [INSTR_W-1:0] w_fetch_instr;
  logic [31:0]        w_fetch_pc;
  logic               w_redirect;
  logic [31:0]        w_pc_next;

  if_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_skid_load),
    .load_instr (imem_rdata),
    .load_pc    (r_pc),
    .pop        (w_skid_pop),
    .valid      (w_skid_valid),
    .instr      (w_skid_instr),
    .pc         (w_skid_pc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_REQ;
    else        r_state <= w_state_next;
  end

  // Next-state, memory handshake and skid control.
  always_comb begin
    w_state_next  = r_state;
    imem_req      = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_pop    = 1'b0;
    w_fetch_done  = 1'b0;
    w_fetch_instr = imem_rdata;
    w_fetch_pc    = r_pc;
    case (r_state)
      ST_REQ: begin
        imem_req = r_run;
        if (r_run && imem_gnt) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (!id_stall) begin
            w_fetch_done = 1'b1;
            w_state_next = ST_REQ;
          end else begin
            w_skid_load  = 1'b1;
            w_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        w_fetch_instr = w_skid_instr;
        w_fetch_pc    = w_skid_pc;
        if (!id_stall && w_skid_valid) begin
          w_fetch_done = 1'b1;
          w_skid_pop   = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_REQ;
    endcase
  end

  assign imem_addr     = word_align(r_pc);
  assign delay_slot_pc = r_pc;

  // The instruction in IF when ID resolves a branch is the delay slot;
  // only its successor is redirected.
  assign w_redirect = id_valid & is_branch & ~id_stall;
  assign w_pc_next  = r_pending  ? r_pending_pc :
                      w_redirect ? word_align(branch_pc) :
                                   r_pc + 32'd4;

  // Hold off the first request by one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // PC advance on fetch completion; remember a redirect that arrives
  // before the delay-slot fetch has completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= word_align(RESET_PC);
      r_pending    <= 1'b0;
      r_pending_pc <= 32'h0;
    end else if (w_fetch_done) begin
      r_pc      <= w_pc_next;
      r_pending <= 1'b0;
    end else if (w_redirect) begin
      r_pending    <= 1'b1;
      r_pending_pc <= word_align(branch_pc);
    end
  end

  // IF/ID register: load on completion, bubble when ID consumes its
  // instruction with nothing new arriving, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= 32'h0;
    end else if (w_fetch_done) begin
      id_valid <= 1'b1;
      id_instr <= w_fetch_instr;
      id_pc    <= w_fetch_pc;
    end else if (!id_stall) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Count IF/ID writes and cycles spent waiting on a stalled ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (w_fetch_done) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((r_state == ST_HOLD) || ((r_state == ST_WAIT) && id_stall))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  // The memory may only respond to a request it has already granted.
  a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_req && imem_rvalid));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ==================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Self-checking bench for if_fetch_unit with a reactive
//            memory and a transaction-level fetch/ID reference model.
// Revision : 1.0 - initial release
// ==================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall = 1'b0;
  logic        is_branch = 1'b0;
  logic [31:0] branch_pc = 32'h0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [31:0] delay_slot_pc;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: memory bookkeeping plus program-order state.
  logic        m_run, m_out, m_parked, m_pend, m_idv;
  int          m_wait;
  logic [31:0] m_out_addr, m_pc, m_tgt, m_idi, m_idp;
  int          gnt_pct = 100;
  int          lat = 1;        // 0 = random latency 1..4

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .is_branch(is_branch), .branch_pc(branch_pc),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
    .delay_slot_pc(delay_slot_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2408_0001;
    return {~a[15:0], a[31:16]} ^ 32'h0F0F_0000;
  endfunction

  // One clock of environment + model; called and returns at posedge+1.
  task automatic cycle();
    logic rd, done, redir;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
    if (m_out && m_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(m_out_addr);
    end else if (!m_out && imem_req && int'($urandom_range(0, 99)) < gnt_pct) begin
      imem_gnt = 1'b1;
    end
    rd    = imem_rvalid;
    redir = m_idv && is_branch && !id_stall;
    done  = !id_stall && (rd || m_parked);
    if (done) begin
      m_idv = 1'b1; m_idi = mem_word(m_pc); m_idp = m_pc;
      m_pc  = m_pend ? m_tgt : (redir ? (branch_pc & ~32'd3) : m_pc + 32'd4);
      m_pend = 1'b0; m_parked = 1'b0;
    end else begin
      if (!id_stall) begin m_idv = 1'b0; m_idi = NOP; end
      if (redir) begin m_pend = 1'b1; m_tgt = branch_pc & ~32'd3; end
      if (rd) m_parked = 1'b1;
    end
    if (rd) m_out = 1'b0;
    else if (m_out) m_wait--;
    if (imem_gnt) begin
      m_out = 1'b1; m_out_addr = imem_addr;
      m_wait = (lat == 0) ? int'($urandom_range(0, 3)) : lat - 1;
    end
    @(posedge clk); #1;
    m_run = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_stall = 1'b0; is_branch = 1'b0;
    m_run = 1'b0; m_out = 1'b0; m_parked = 1'b0; m_pend = 1'b0; m_wait = 0;
    m_idv = 1'b0; m_idi = NOP; m_idp = 32'h0; m_pc = RST_PC; m_tgt = 32'h0; m_out_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", id_instr, NOP); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    n_cmp++; if (delay_slot_pc !== RST_PC) begin n_err++; $display("FAIL reset_dspc: got %h want %h", delay_slot_pc, RST_PC); end
    do_reset();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL release_req0: got %b want 0", imem_req); end
    cycle();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL first_addr: got %h want %h", imem_addr, RST_PC); end
  endtask

  task automatic test_first_fetch();
    cycle();   // grant
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL ff_early_valid: got %b want 0", id_valid); end
    cycle();   // response
    n_cmp++; if (id_instr !== 32'h2408_0001) begin n_err++; $display("FAIL ff_instr: got %h want 24080001", id_instr); end
    n_cmp++; if (id_pc !== 32'h0040_0000) begin n_err++; $display("FAIL ff_pc: got %h want 00400000", id_pc); end
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL ff_valid: got %b want 1", id_valid); end
    n_cmp++; if (imem_addr !== 32'h0040_0004) begin n_err++; $display("FAIL ff_next_addr: got %h want 00400004", imem_addr); end
  endtask

  task automatic test_branch_delay_slot();
    cycle(); cycle();                 // fetch 0x00400004 into ID
    id_stall = 1'b1; cycle();         // grant 0x00400008, ID held
    n_cmp++; if (delay_slot_pc !== 32'h0040_0008) begin n_err++; $display("FAIL br_dspc: got %h want 00400008", delay_slot_pc); end
    id_stall = 1'b0; is_branch = 1'b1; branch_pc = 32'h0040_0100;
    cycle();
    is_branch = 1'b0;
    n_cmp++; if (id_pc !== 32'h0040_0008) begin n_err++; $display("FAIL br_slot_pc: got %h want 00400008", id_pc); end
    n_cmp++; if (id_instr !== mem_word(32'h0040_0008)) begin n_err++; $display("FAIL br_slot_instr: got %h want %h", id_instr, mem_word(32'h0040_0008)); end
    n_cmp++; if (imem_addr !== 32'h0040_0100) begin n_err++; $display("FAIL br_target: got %h want 00400100", imem_addr); end
  endtask

  task automatic test_pending_redirect();
    int k;
    lat = 3;
    id_stall = 1'b1; cycle();         // grant 0x00400100
    id_stall = 1'b0; is_branch = 1'b1; branch_pc = 32'h0040_0200;
    cycle();
    is_branch = 1'b0;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL pend_bubble: got %b want 0", id_valid); end
    k = 0;
    while (id_valid !== 1'b1 && k < 8) begin cycle(); k++; end
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL pend_timeout: got valid %b want 1 within 8 cycles", id_valid); end
    n_cmp++; if (id_pc !== 32'h0040_0100) begin n_err++; $display("FAIL pend_slot_pc: got %h want 00400100", id_pc); end
    n_cmp++; if (imem_addr !== 32'h0040_0200) begin n_err++; $display("FAIL pend_target: got %h want 00400200", imem_addr); end
    lat = 1;
  endtask

  task automatic test_stall_hold();
    logic [31:0] held;
    held = id_instr;
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (id_instr !== held) begin n_err++; $display("FAIL hold_instr[%0d]: got %h want %h", i, id_instr, held); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
    end
    id_stall = 1'b0; cycle();
    n_cmp++; if (id_pc !== 32'h0040_0200) begin n_err++; $display("FAIL hold_out_pc: got %h want 00400200", id_pc); end
    n_cmp++; if (id_instr !== mem_word(32'h0040_0200)) begin n_err++; $display("FAIL hold_out_instr: got %h want %h", id_instr, mem_word(32'h0040_0200)); end
    n_cmp++; if (imem_addr !== 32'h0040_0204) begin n_err++; $display("FAIL hold_next_addr: got %h want 00400204", imem_addr); end
    cycle();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL hold_no_dup: got %b want 0", id_valid); end
  endtask

  task automatic test_pc_wrap();
    cycle();                          // 0x00400204 into ID
    id_stall = 1'b1; cycle();         // grant 0x00400208
    id_stall = 1'b0; is_branch = 1'b1; branch_pc = 32'hFFFF_FFFF;
    cycle();
    is_branch = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align: got %h want fffffffc", imem_addr); end
    cycle(); cycle();
    n_cmp++; if (id_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc: got %h want fffffffc", id_pc); end
    n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_next: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    lat = 5;
    id_stall = 1'b1; cycle();         // grant 0x00000000
    id_stall = 1'b0; is_branch = 1'b1; branch_pc = 32'h0000_1000;
    cycle();                          // redirect pending, fetch outstanding
    is_branch = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rw_req: got %b want 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rw_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_instr !== NOP) begin n_err++; $display("FAIL rw_instr: got %h want %h", id_instr, NOP); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rw_pc: got %h want 0", id_pc); end
    n_cmp++; if (delay_slot_pc !== RST_PC) begin n_err++; $display("FAIL rw_dspc: got %h want %h", delay_slot_pc, RST_PC); end
    do_reset();
    lat = 1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;   // stale response
    @(posedge clk); #1;
    imem_rvalid = 1'b0; m_run = 1'b1;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rw_stale: got valid %b want 0", id_valid); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL rw_addr: got %h want %h", imem_addr, RST_PC); end
    cycle(); cycle();
    n_cmp++; if (id_instr !== 32'h2408_0001) begin n_err++; $display("FAIL rw_instr2: got %h want 24080001", id_instr); end
    n_cmp++; if (imem_addr !== 32'h0040_0004) begin n_err++; $display("FAIL rw_pend_clr: got %h want 00400004", imem_addr); end
  endtask

  task automatic test_random();
    logic exp_req;
    do_reset();
    gnt_pct = 60; lat = 0;
    for (int i = 0; i < 600; i++) begin
      id_stall  = (int'($urandom_range(0, 99)) < 30);
      is_branch = (int'($urandom_range(0, 99)) < 20);
      branch_pc = $urandom;
      cycle();
      exp_req = m_run && !m_out && !m_parked;
      n_cmp++; if (imem_req !== exp_req) begin n_err++; $display("FAIL rnd_req@%0d: got %b want %b", i, imem_req, exp_req); end
      n_cmp++; if (delay_slot_pc !== m_pc) begin n_err++; $display("FAIL rnd_dspc@%0d: got %h want %h", i, delay_slot_pc, m_pc); end
      if (exp_req) begin
        n_cmp++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_pc); end
      end
      n_cmp++; if (id_valid !== m_idv) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", i, id_valid, m_idv); end
      n_cmp++; if (id_instr !== m_idi) begin n_err++; $display("FAIL rnd_instr@%0d: got %h want %h", i, id_instr, m_idi); end
      if (m_idv) begin
        n_cmp++; if (id_pc !== m_idp) begin n_err++; $display("FAIL rnd_pc@%0d: got %h want %h", i, id_pc, m_idp); end
      end
    end
    id_stall = 1'b0; is_branch = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch_delay_slot();
    test_pending_redirect();
    test_stall_hold();
    test_pc_wrap();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch (IF) stage that directly feeds the ID-stage branch resolver.
- Owns the program counter and issues requests to a variable-latency instruction memory. Holds the IF/ID pipeline register.
- Applies branch/jump redirects from ID with MIPS single-delay-slot semantics.
- Provides `delay_slot_pc` (the PC of the instruction currently in IF) back to ID.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word presented on `id_instr` when `id_valid` = 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  32  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; exactly one response per granted request, in order.
- imem_rdata  in  32  instruction word.
- id_stall  in  1  hazard unit holds ID; IF/ID register must not advance.
- is_branch  in  1  ID-stage instruction redirects control flow.
- branch_pc  in  32  redirect target from ID.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  PC of `id_instr`.
- id_valid  out  1  `id_instr` is a real instruction.
- delay_slot_pc  out  32  PC of the instruction currently being fetched.

Behaviour:
- Reset (async, `rst_n` = 0):
  - pc = RESET_PC, FSM = REQ, `imem_req` = 0.
  - `id_valid` = 0, `id_instr` = NOP_INSTR, `id_pc` = 0.
  - Skid buffer empty, redirect pending flag = 0.
  - All outputs take these values immediately on reset assertion.
  - First `imem_req` is asserted the cycle after reset deasserts.
- FSM states:
  - REQ: `imem_req` = 1, `imem_addr` = pc. On `imem_gnt` go to WAIT. `imem_addr` is stable until granted.
  - WAIT: outstanding fetch; `imem_req` = 0. On `imem_rvalid`:
    - If `id_stall` = 0: write IF/ID, compute next pc, go to REQ.
    - Else: capture the response into the skid buffer and go to HOLD.
  - HOLD: response parked in the skid buffer. When `id_stall` = 0: move the skid buffer into IF/ID, compute next pc, go to REQ.
- Same-cycle response: when `imem_gnt` and `imem_rvalid` arrive in the same cycle (zero-latency memory), a response is legal only in WAIT. `imem_rvalid` in REQ is a protocol error (assertion).
- IF/ID register write: `id_instr` = fetched word, `id_pc` = fetch pc, `id_valid` = 1.
- When `id_stall` = 0 and no fetch response completes this cycle, the ID instruction is consumed. In that case `id_valid` = 0 and `id_instr` = NOP_INSTR (bubble).
- Redirect event = `id_valid` & `is_branch` & ~`id_stall`.
  - The instruction in IF at that moment is the delay slot and is always kept.
  - Its successor comes from `branch_pc` instead of pc+4.
  - If the delay-slot fetch has not yet completed, set pending = 1 and latch `branch_pc`. It is applied when that fetch completes, then pending is cleared.
  - Next pc = pending ? latched target : (redirect this cycle ? `branch_pc` : pc+4).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. `imem_addr[1:0]` is always 2'b00; target bits [1:0] are ignored.
- `delay_slot_pc` = pc, the address of the in-flight or next-issued fetch.
- Latency: a granted fetch with 1-cycle rvalid appears on `id_instr` on the edge after rvalid. Steady-state throughput is one instruction per 2 cycles.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs `perf_fetch_cnt[31:0]` (increments per IF/ID write) and `perf_stall_cnt[31:0]` (increments per cycle in HOLD, or in WAIT while `id_stall` = 1). Both reset to 0 and wrap.
- Undefined: neither the ports nor the counter logic exist.

Decomposition:
- Shared package:
  - FSM state encoding: REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2.
  - RESET_PC and NOP_INSTR defaults.
  - Instruction word width 32.
- One natural sub-module: `if_skid_buffer`, a one-entry instr/pc holding register with a valid flag.

Test Plan:
- Reset release, 1-cycle memory returning 32'h2408_0001 at 0x0040_0000 -> `id_instr` = 32'h2408_0001, `id_pc` = 0x0040_0000, `id_valid` = 1; next `imem_addr` = 0x0040_0004.
- Taken branch in ID (`is_branch` = 1, `branch_pc` = 0x0040_0100) while fetching 0x0040_0008 -> 0x0040_0008 reaches ID (delay slot); the following `imem_addr` = 0x0040_0100.
- Redirect while in WAIT with 3-cycle memory latency -> pending latched; after rvalid the next request goes to `branch_pc`, not pc+4.
- `id_stall` = 1 for 4 cycles across an rvalid -> FSM enters HOLD, `id_instr` unchanged, no new `imem_req`. On release the skid word enters ID with no loss or duplication.
- PC at 32'hFFFF_FFFC with no redirect -> next `imem_addr` = 32'h0000_0000.
- `rst_n` asserted in WAIT, including while a `branch_pc` redirect is pending -> all outputs return to reset values immediately and pending clears. The first request after release goes to 0x0040_0000, and the stale rvalid is ignored.
